// File: rtl/regfile_wr_arbiter.sv
// Single write-port arbiter for the 32x32 register file: post-reset clear sweep,
// writeback priority, buffered UART writes with starvation guard. Optional REGARB_WRCOUNT_EN.
module regfile_wr_arbiter #(
  parameter int          INIT_CLEAR = 1,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
  parameter int          STARVE_MAX = 8
) (
  input  logic        clk_o,
  input  logic        rst_n,
  input  logic        wb_wr_i,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        uart_req_valid_i,
  output logic        uart_req_ready_o,
  input  logic [4:0]  uart_waddr_i,
  input  logic [31:0] uart_wdata_i,
  output logic        uart_ack_o,
  output logic        stall_o,
  output logic        init_done_o,
`ifdef REGARB_WRCOUNT_EN
  output logic [15:0] wrcount_o,
`endif
  output logic        rf_wr_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FORCE} state_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_req_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t     state;
  logic [4:0] init_ptr;
  logic       buf_vld;
  wr_req_t    buf_q;
  logic [7:0] starve_cnt;
  logic       wb_hit;
  logic       drain;

  // Writeback to x0 is not a real write and leaves the slot to UART.
  assign wb_hit           = wb_wr_i && (wb_waddr_i != 5'd0);
  assign drain            = (state == ST_FORCE) || (state == ST_RUN && !wb_hit && buf_vld);
  assign uart_req_ready_o = !buf_vld && (state != ST_INIT);

  always_ff @(posedge clk_o or negedge rst_n) begin
    if (!rst_n) begin
      state       <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      init_ptr    <= 5'd1;
      buf_vld     <= 1'b0;
      buf_q       <= '0;
      starve_cnt  <= 8'd0;
      rf_wr_o     <= 1'b0;
      rf_waddr_o  <= 5'd0;
      rf_wdata_o  <= 32'd0;
      uart_ack_o  <= 1'b0;
      stall_o     <= (INIT_CLEAR != 0);
      init_done_o <= (INIT_CLEAR == 0);
    end else begin
      uart_ack_o <= 1'b0;
      if (uart_req_valid_i && uart_req_ready_o) begin
        buf_vld    <= 1'b1;
        buf_q.addr <= uart_waddr_i;
        buf_q.data <= uart_wdata_i;
      end
      if (drain) begin
        // A buffered write to x0 is dropped but still acknowledged.
        rf_wr_o    <= (buf_q.addr != 5'd0);
        rf_waddr_o <= buf_q.addr;
        rf_wdata_o <= buf_q.data;
        buf_vld    <= 1'b0;
        uart_ack_o <= 1'b1;
        starve_cnt <= 8'd0;
      end
      case (state)
        ST_INIT: begin
          rf_wr_o    <= 1'b1;
          rf_waddr_o <= init_ptr;
          rf_wdata_o <= INIT_VALUE;
          init_ptr   <= init_ptr + 5'd1;
          if (init_ptr == 5'd31) begin
            state       <= ST_RUN;
            init_done_o <= 1'b1;
            stall_o     <= 1'b0;
          end
        end
        ST_RUN: begin
          if (wb_hit) begin
            rf_wr_o    <= 1'b1;
            rf_waddr_o <= wb_waddr_i;
            rf_wdata_o <= wb_wdata_i;
            if (buf_vld) begin
              starve_cnt <= starve_cnt + 8'd1;
              if (starve_cnt + 8'd1 == STARVE_LIM) begin
                state   <= ST_FORCE;
                stall_o <= 1'b1;
              end
            end
          end else if (!buf_vld) begin
            rf_wr_o <= 1'b0;
          end
        end
        ST_FORCE: begin
          stall_o <= 1'b0;
          state   <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef REGARB_WRCOUNT_EN
  // Counts only UART writes that reach the register file; saturates.
  always_ff @(posedge clk_o or negedge rst_n) begin
    if (!rst_n)
      wrcount_o <= 16'd0;
    else if (drain && buf_q.addr != 5'd0 && wrcount_o != 16'hFFFF)
      wrcount_o <= wrcount_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: driver runs a reference model and queues
// expectations, monitor pops and compares what the DUT presents each cycle.
module tb_regfile_wr_arbiter;
  localparam logic [31:0] INIT_VALUE = 32'h0000_0000;
  localparam int          SM         = 8;

  logic        clk_o = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_wr_i = 1'b0;
  logic [4:0]  wb_waddr_i = '0;
  logic [31:0] wb_wdata_i = '0;
  logic        uart_req_valid_i = 1'b0;
  logic [4:0]  uart_waddr_i = '0;
  logic [31:0] uart_wdata_i = '0;
  logic        uart_req_ready_o, uart_ack_o, stall_o, init_done_o;
  logic        rf_wr_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
`ifdef REGARB_WRCOUNT_EN
  logic [15:0] wrcount_o;
`endif

  always #5 clk_o = ~clk_o;

  regfile_wr_arbiter dut (
    .clk_o(clk_o), .rst_n(rst_n),
    .wb_wr_i(wb_wr_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .uart_req_valid_i(uart_req_valid_i), .uart_req_ready_o(uart_req_ready_o),
    .uart_waddr_i(uart_waddr_i), .uart_wdata_i(uart_wdata_i),
    .uart_ack_o(uart_ack_o), .stall_o(stall_o), .init_done_o(init_done_o),
`ifdef REGARB_WRCOUNT_EN
    .wrcount_o(wrcount_o),
`endif
    .rf_wr_o(rf_wr_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  typedef struct {
    bit wr;
    bit ack;
    bit stall;
    bit ready;
    bit done;
  } st_t;

  st_t         st_q[$];
  logic [36:0] wr_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: sweep progress, pending UART entry, consecutive losses.
  bit          m_init, m_force, b_v;
  int          m_ptr, starve, cnt;
  logic [4:0]  b_a;
  logic [31:0] b_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_ptr = 1; m_force = 0; b_v = 0; starve = 0; cnt = 0;
    st_q.delete(); wr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rf_wr"}, rf_wr_o, 0);
    chk({tag, "_rf_waddr"}, rf_waddr_o, 0);
    chk({tag, "_rf_wdata"}, rf_wdata_o, 0);
    chk({tag, "_ack"}, uart_ack_o, 0);
    chk({tag, "_stall"}, stall_o, 1);
    chk({tag, "_done"}, init_done_o, 0);
    chk({tag, "_ready"}, uart_req_ready_o, 0);
  endtask

  // Drive one cycle at the negedge and predict what the next posedge produces.
  task automatic step(input bit ww, input logic [4:0] wa, input logic [31:0] wd,
                      input bit uv, input logic [4:0] ua, input logic [31:0] ud);
    st_t e;
    bit  acc;
    wb_wr_i = ww; wb_waddr_i = wa; wb_wdata_i = wd;
    uart_req_valid_i = uv; uart_waddr_i = ua; uart_wdata_i = ud;
    acc = uv && !b_v && !m_init;
    e.wr = 0; e.ack = 0;
    if (m_init) begin
      e.wr = 1;
      wr_q.push_back({5'(m_ptr), INIT_VALUE});
      m_ptr++;
      if (m_ptr == 32) m_init = 0;
    end else if (!m_force && ww && wa != 0) begin
      e.wr = 1;
      wr_q.push_back({wa, wd});
      if (b_v) begin
        starve++;
        if (starve == SM) m_force = 1;
      end
    end else if (b_v) begin
      e.ack = 1;
      if (b_a != 0) begin
        e.wr = 1;
        wr_q.push_back({b_a, b_d});
        cnt++;
      end
      b_v = 0; starve = 0; m_force = 0;
    end
    if (acc) begin
      b_v = 1; b_a = ua; b_d = ud;
    end
    e.stall = m_init || m_force;
    e.ready = !b_v && !m_init;
    e.done  = !m_init;
    st_q.push_back(e);
    @(negedge clk_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // Monitor: compares the DUT's presented outputs against queued expectations.
  always @(posedge clk_o) begin
    st_t         e;
    logic [36:0] w;
    #1;
    if (rst_n && st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("rf_wr", rf_wr_o, e.wr);
      chk("uart_ack", uart_ack_o, e.ack);
      chk("stall", stall_o, e.stall);
      chk("ready", uart_req_ready_o, e.ready);
      chk("init_done", init_done_o, e.done);
      if (rf_wr_o) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          w = wr_q.pop_front();
          chk("rf_waddr", rf_waddr_o, w[36:32]);
          chk("rf_wdata", rf_wdata_o, w[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk_o);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(33);

    // Uncontended UART write.
    step(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEAD_BEEF);
    idle(3);

    // Continuous writeback starving a pending UART write.
    step(1, 5'd3, 32'h1111_0000, 1, 5'd7, 32'hCAFE_F00D);
    for (int i = 1; i <= 12; i++) step(1, 5'd3, 32'h1111_0000 + i, 0, 5'd0, 32'd0);
    idle(2);

    // UART to x0 is dropped; writeback to x0 leaves the slot to UART.
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'h1234_5678);
    idle(2);
    step(1, 5'd9, 32'h9999_9999, 1, 5'd12, 32'hABCD_0012);
    step(1, 5'd0, 32'h0BAD_0BAD, 0, 5'd0, 32'd0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, ua;
      wa = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      ua = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 9) < 6, wa, $urandom, $urandom_range(0, 9) < 4, ua, $urandom);
    end
`ifdef REGARB_WRCOUNT_EN
    chk("wrcount_random", wrcount_o, 64'(cnt));
`endif

    // Reset with an entry buffered: immediate reset values, no ack, sweep restarts.
    for (int i = 0; i < 20 && !b_v; i++)
      step(1, 5'd4, $urandom, 1, 5'd6, $urandom);
    chk("buffered_before_reset", b_v, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(negedge clk_o);
    rst_n = 1'b1;
    idle(33);

    // Three real UART writes plus one to x0.
    step(0, 5'd0, 32'd0, 1, 5'd1, 32'h0000_00A1); idle(1);
    step(0, 5'd0, 32'd0, 1, 5'd2, 32'h0000_00A2); idle(1);
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'h0000_00A0); idle(1);
    step(0, 5'd0, 32'd0, 1, 5'd3, 32'h0000_00A3); idle(2);
`ifdef REGARB_WRCOUNT_EN
    chk("wrcount_3", wrcount_o, 3);
`endif
    chk("st_q_drained", st_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
